switch_conditioner: RTL and testbench

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

---
 rtl/wack_a_mole_pkg.sv | 10 +
 rtl/switch_conditioner_debounce_cell.sv | 88 ++++++++
 rtl/switch_conditioner.sv | 60 ++++++
 tb/tb_switch_conditioner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/wack_a_mole_pkg.sv
// Shared game package: switch count, clock frequency and debounce defaults
// used across the wack_a_mole blocks.
package wack_a_mole_pkg;

    localparam int NUM_SW_DEFAULT          = 9;
    localparam int CLK_FREQ_HZ             = 50_000_000;
    // 20 ms of stable input at the nominal clock frequency
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_FREQ_HZ / 50;

endpackage

// File: rtl/switch_conditioner_debounce_cell.sv
// One switch channel: 2-flop synchronizer, disagreement counter, debounced
// level and registered one-cycle press/release pulses gated by enable.
module debounce_cell
    import wack_a_mole_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    input  logic enable,
    output logic sw_level,
    output logic sw_press,
    output logic sw_release,
    output logic press_next
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          level_r;
    logic          level_nxt_s;
    logic          qualify_s;
    logic          press_r;
    logic          release_r;
    logic          release_next_s;

    // Bring the asynchronous switch into the clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= sw_raw;
            sync2_r <= sync1_r;
        end
    end

    // Qualify a disagreement that lasts DEBOUNCE_CYCLES consecutive cycles;
    // any agreeing cycle restarts the count, and the count never wraps
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        qualify_s   = 1'b0;
        if (sync2_r != level_r) begin
            if (cnt_r == CNT_MAX) begin
                qualify_s   = 1'b1;
                level_nxt_s = sync2_r;
                cnt_nxt_s   = '0;
            end else begin
                cnt_nxt_s   = cnt_r + CW'(1);
            end
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // Pulses fire only on the qualifying edge itself, so enabling later
    // while the switch is held produces nothing
    always_comb begin
        press_next     = qualify_s & sync2_r & enable;
        release_next_s = qualify_s & ~sync2_r & enable;
    end

    // Counter, level and pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r     <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            press_r   <= press_next;
            release_r <= release_next_s;
        end
    end

    assign sw_level   = level_r;
    assign sw_press   = press_r;
    assign sw_release = release_r;

endmodule

// File: rtl/switch_conditioner.sv
// Switch conditioner: one debounce_cell per switch plus a registered
// multi_press flag when two or more presses land in the same cycle.
module switch_conditioner
    import wack_a_mole_pkg::*;
#(
    parameter int NUM_SW          = NUM_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    input  logic              enable,
    output logic [NUM_SW-1:0] sw_level,
    output logic [NUM_SW-1:0] sw_press,
    output logic [NUM_SW-1:0] sw_release,
    output logic              multi_press
);

    logic [NUM_SW-1:0] press_next_s;
    logic              seen_s;
    logic              multi_next_s;
    logic              multi_r;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .sw_raw     (sw_raw[g]),
            .enable     (enable),
            .sw_level   (sw_level[g]),
            .sw_press   (sw_press[g]),
            .sw_release (sw_release[g]),
            .press_next (press_next_s[g])
        );
    end

    // Detect two or more presses about to be registered this edge
    always_comb begin
        seen_s       = 1'b0;
        multi_next_s = 1'b0;
        for (int i = 0; i < NUM_SW; i++) begin
            multi_next_s = multi_next_s | (seen_s & press_next_s[i]);
            seen_s       = seen_s | press_next_s[i];
        end
    end

    // Register multi_press so it coincides with the cell press pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            multi_r <= 1'b0;
        end else begin
            multi_r <= multi_next_s;
        end
    end

    assign multi_press = multi_r;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with DEBOUNCE_CYCLES = 4.
module tb_switch_conditioner;

    localparam int N = 9;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] sw_raw;
    logic         enable;
    logic [N-1:0] sw_level;
    logic [N-1:0] sw_press;
    logic [N-1:0] sw_release;
    logic         multi_press;

    int checks_r;
    int fails_r;
    int glitch_bad_r;
    bit glitch_mode_r;

    switch_conditioner #(
        .NUM_SW          (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .enable      (enable),
        .sw_level    (sw_level),
        .sw_press    (sw_press),
        .sw_release  (sw_release),
        .multi_press (multi_press)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Run-time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    // Count any output activity while glitches are being injected
    always @(negedge clk) begin
        if (glitch_mode_r && ((sw_press | sw_release | sw_level) != '0 || multi_press))
            glitch_bad_r++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            fails_r++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        sw_raw = '0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Raise sw_raw[0] for len cycles and check level/press/release timing
    task automatic bounce(input int len, input bit accepted);
        logic lvl_e, prs_e, rel_e;
        sw_raw[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            lvl_e = accepted && (k >= 6) && (k < 10);
            prs_e = accepted && (k == 6);
            rel_e = accepted && (k == 10);
            check_eq($sformatf("bounce%0d_level_k%0d", len, k), 32'(sw_level), 32'(lvl_e));
            check_eq($sformatf("bounce%0d_press_k%0d", len, k), 32'(sw_press), 32'(prs_e));
            check_eq($sformatf("bounce%0d_release_k%0d", len, k), 32'(sw_release), 32'(rel_e));
            if (k == len) sw_raw[0] = 1'b0;
        end
    endtask

    initial begin
        logic [N-1:0] exp_v;
        int           d;
        checks_r      = 0;
        fails_r       = 0;
        glitch_bad_r  = 0;
        glitch_mode_r = 1'b0;
        sw_raw        = '0;
        enable        = 1'b1;
        reset         = 1'b1;

        // Reset state
        #1;
        check_eq("rst_level",   32'(sw_level),    32'(0));
        check_eq("rst_press",   32'(sw_press),    32'(0));
        check_eq("rst_release", 32'(sw_release),  32'(0));
        check_eq("rst_multi",   32'(multi_press), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single press on channel 3: level and press exactly 6 edges later
        sw_raw[3] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_v = (k == 6) ? 9'b000001000 : 9'b000000000;
            check_eq($sformatf("ch3_press_k%0d", k), 32'(sw_press), 32'(exp_v));
            exp_v = (k >= 6) ? 9'b000001000 : 9'b000000000;
            check_eq($sformatf("ch3_level_k%0d", k), 32'(sw_level), 32'(exp_v));
        end

        // Bounce shorter than the qualification window, then exactly the window
        do_reset();
        bounce(3, 1'b0);
        do_reset();
        bounce(4, 1'b1);

        // Simultaneous presses on channels 1 and 7
        do_reset();
        sw_raw[1] = 1'b1;
        sw_raw[7] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_v = (k == 6) ? 9'b010000010 : 9'b000000000;
            check_eq($sformatf("dual_press_k%0d", k), 32'(sw_press), 32'(exp_v));
            check_eq($sformatf("dual_multi_k%0d", k), 32'(multi_press), 32'(k == 6));
        end

        // Press while disabled; enabling while held must not pulse
        do_reset();
        enable    = 1'b0;
        sw_raw[5] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_v = (k >= 6) ? 9'b000100000 : 9'b000000000;
            check_eq($sformatf("dis_level_k%0d", k), 32'(sw_level), 32'(exp_v));
            check_eq($sformatf("dis_press_k%0d", k), 32'(sw_press), 32'(0));
            if (k == 7) enable = 1'b1;
        end

        // Reset in mid-qualification with another channel already high
        do_reset();
        sw_raw[4] = 1'b1;
        repeat (7) @(negedge clk);
        check_eq("pre_rst_level4", 32'(sw_level), 32'(9'b000010000));
        sw_raw[2] = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_level2", 32'(sw_level), 32'(9'b000010000));
        #1 reset = 1'b1;
        #1;
        check_eq("mid_rst_level",   32'(sw_level),    32'(0));
        check_eq("mid_rst_press",   32'(sw_press),    32'(0));
        check_eq("mid_rst_release", 32'(sw_release),  32'(0));
        check_eq("mid_rst_multi",   32'(multi_press), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_v = (k == 6) ? 9'b000010100 : 9'b000000000;
            check_eq($sformatf("post_rst_press_k%0d", k), 32'(sw_press), 32'(exp_v));
            check_eq($sformatf("post_rst_multi_k%0d", k), 32'(multi_press), 32'(k == 6));
            exp_v = (k >= 6) ? 9'b000010100 : 9'b000000000;
            check_eq($sformatf("post_rst_level_k%0d", k), 32'(sw_level), 32'(exp_v));
        end

        // Half-cycle glitches on every channel at random phases
        do_reset();
        glitch_mode_r = 1'b1;
        for (int it = 0; it < 5000; it++) begin
            repeat (2) @(negedge clk);
            d = $urandom_range(1, 8);
            if (d >= 5) d = d + 1;
            #(d);
            sw_raw[it % N] = 1'b1;
            #5;
            sw_raw[it % N] = 1'b0;
        end
        repeat (8) @(negedge clk);
        glitch_mode_r = 1'b0;
        check_eq("glitch_activity", 32'(glitch_bad_r), 32'(0));
        check_eq("glitch_level",    32'(sw_level),     32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks_r, fails_r);
        $finish;
    end

endmodule
